// File: rtl/ex_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage_sequencer
// Description : Execute-stage sequencer. Decodes the ID/EX operation class,
//               drives the EX/MEM input mux selects and load strobe, runs
//               multi-cycle ALU operations with a latency down-counter,
//               stalls ID/EX while waiting, and keeps a saturating
//               stall-cycle counter for performance debug.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage_sequencer #(
  parameter int MUL_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        id_ex_valid,
  input  logic [2:0]  op_class,
  input  logic        ex_mem_ready,
  output logic [1:0]  sel_signals,
  output logic        ex_mem_load,
  output logic        alu_start,
  output logic        stall_id,
  output logic        busy,
  output logic [15:0] stall_cycles
);

  // Operation class encodings as seen in ID/EX.
  localparam logic [2:0] c_op_nop     = 3'd0;
  localparam logic [2:0] c_op_pass    = 3'd1;
  localparam logic [2:0] c_op_alu_top = 3'd2;
  localparam logic [2:0] c_op_alu_bot = 3'd3;
  localparam logic [2:0] c_op_alu16   = 3'd4;
  localparam logic [2:0] c_op_multi   = 3'd5;

  // Mux select patterns: bit0 = top byte from ALU, bit1 = bottom byte from ALU.
  localparam logic [1:0] c_sel_pass = 2'b00;
  localparam logic [1:0] c_sel_top  = 2'b01;
  localparam logic [1:0] c_sel_bot  = 2'b10;
  localparam logic [1:0] c_sel_both = 2'b11;

  // The counter is loaded with latency-1 in the accept cycle, so the load
  // lands MUL_CYCLES cycles after the start pulse.
  localparam logic [3:0]  c_cnt_init  = 4'(MUL_CYCLES - 1);
  localparam logic [15:0] c_stall_max = 16'hFFFF;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_MULTI = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [15:0] r_stall_cycles;

  logic [1:0]  w_dec_sel;
  logic        w_dec_single;
  logic        w_dec_multi;

  // Decode the op class into a mux pattern and single/multi-cycle kind;
  // NOP and the unused codes 6/7 decode to neither kind.
  always_comb begin
    w_dec_sel    = c_sel_pass;
    w_dec_single = 1'b0;
    w_dec_multi  = 1'b0;
    case (op_class)
      c_op_nop: begin
        w_dec_sel = c_sel_pass;
      end
      c_op_pass: begin
        w_dec_sel    = c_sel_pass;
        w_dec_single = 1'b1;
      end
      c_op_alu_top: begin
        w_dec_sel    = c_sel_top;
        w_dec_single = 1'b1;
      end
      c_op_alu_bot: begin
        w_dec_sel    = c_sel_bot;
        w_dec_single = 1'b1;
      end
      c_op_alu16: begin
        w_dec_sel    = c_sel_both;
        w_dec_single = 1'b1;
      end
      c_op_multi: begin
        w_dec_sel   = c_sel_both;
        w_dec_multi = 1'b1;
      end
      default: begin
        w_dec_sel = c_sel_pass;
      end
    endcase
  end

  // Next-state and output logic; reset forces everything quiet, flush kills
  // any load/start and releases the stall, then normal sequencing applies.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    sel_signals = c_sel_pass;
    ex_mem_load = 1'b0;
    alu_start   = 1'b0;
    stall_id    = 1'b0;
    busy        = 1'b0;

    if (reset) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 4'd0;
    end else if (flush) begin
      busy        = (r_state == ST_MULTI);
      sel_signals = (r_state == ST_MULTI) ? c_sel_both
                  : (id_ex_valid ? w_dec_sel : c_sel_pass);
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (id_ex_valid && w_dec_single) begin
            sel_signals = w_dec_sel;
            ex_mem_load = ex_mem_ready;
            stall_id    = ~ex_mem_ready;
          end else if (id_ex_valid && w_dec_multi) begin
            sel_signals = c_sel_both;
            alu_start   = 1'b1;
            stall_id    = 1'b1;
            w_state_nxt = ST_MULTI;
            w_cnt_nxt   = c_cnt_init;
          end
        end
        ST_MULTI: begin
          busy        = 1'b1;
          sel_signals = c_sel_both;
          if (r_cnt != 4'd0) begin
            w_cnt_nxt = r_cnt - 4'd1;
            stall_id  = 1'b1;
          end else if (ex_mem_ready) begin
            ex_mem_load = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            stall_id = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  // State and latency counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Saturating count of stalled cycles; only reset clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_cycles <= 16'd0;
    end else if (stall_id && (r_stall_cycles != c_stall_max)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_stage_sequencer
// Description : Directed self-checking bench for ex_stage_sequencer
//               (MUL_CYCLES = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage_sequencer;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        id_ex_valid;
  logic [2:0]  op_class;
  logic        ex_mem_ready;
  logic [1:0]  sel_signals;
  logic        ex_mem_load;
  logic        alu_start;
  logic        stall_id;
  logic        busy;
  logic [15:0] stall_cycles;

  int n_cmp = 0;
  int n_err = 0;

  ex_stage_sequencer #(.MUL_CYCLES(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .id_ex_valid  (id_ex_valid),
    .op_class     (op_class),
    .ex_mem_ready (ex_mem_ready),
    .sel_signals  (sel_signals),
    .ex_mem_load  (ex_mem_load),
    .alu_start    (alu_start),
    .stall_id     (stall_id),
    .busy         (busy),
    .stall_cycles (stall_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Check all single-bit/select outputs of the current cycle at once.
  task automatic check_outs(input string tag, input logic [1:0] e_sel, input logic e_load,
                            input logic e_start, input logic e_stall, input logic e_busy);
    check({tag, ".sel"},   32'(sel_signals), 32'(e_sel));
    check({tag, ".load"},  32'(ex_mem_load), 32'(e_load));
    check({tag, ".start"}, 32'(alu_start),   32'(e_start));
    check({tag, ".stall"}, 32'(stall_id),    32'(e_stall));
    check({tag, ".busy"},  32'(busy),        32'(e_busy));
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic rdy, input logic fl);
    id_ex_valid  = v;
    op_class     = op;
    ex_mem_ready = rdy;
    flush        = fl;
  endtask

  // Inputs are applied just after a rising edge; outputs are sampled on the
  // falling edge; then advance to just after the next rising edge.
  task automatic to_sample();
    @(negedge clock);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b1, 3'd1, 1'b1, 1'b0);
    #1;

    // Reset forces outputs low even with a valid PASS presented.
    to_sample();
    check_outs("rst", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    drive(1'b1, 3'd5, 1'b1, 1'b0);
    to_sample();
    check_outs("rst_multi", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst.stall_cycles", 32'(stall_cycles), 32'd0);
    next_cycle();
    reset = 1'b0;

    // Single-cycle classes, back to back.
    drive(1'b1, 3'd1, 1'b1, 1'b0); to_sample(); check_outs("pass",    2'b00, 1'b1, 1'b0, 1'b0, 1'b0); next_cycle();
    drive(1'b1, 3'd2, 1'b1, 1'b0); to_sample(); check_outs("alu_top", 2'b01, 1'b1, 1'b0, 1'b0, 1'b0); next_cycle();
    drive(1'b1, 3'd3, 1'b1, 1'b0); to_sample(); check_outs("alu_bot", 2'b10, 1'b1, 1'b0, 1'b0, 1'b0); next_cycle();
    drive(1'b1, 3'd4, 1'b1, 1'b0); to_sample(); check_outs("alu16",   2'b11, 1'b1, 1'b0, 1'b0, 1'b0); next_cycle();
    drive(1'b1, 3'd6, 1'b1, 1'b0); to_sample(); check_outs("op6",     2'b00, 1'b0, 1'b0, 1'b0, 1'b0); next_cycle();
    drive(1'b1, 3'd7, 1'b1, 1'b0); to_sample(); check_outs("op7",     2'b00, 1'b0, 1'b0, 1'b0, 1'b0); next_cycle();
    drive(1'b1, 3'd0, 1'b1, 1'b0); to_sample(); check_outs("nop",     2'b00, 1'b0, 1'b0, 1'b0, 1'b0); next_cycle();
    drive(1'b0, 3'd4, 1'b1, 1'b0); to_sample(); check_outs("invalid", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); next_cycle();
    // Single-cycle class blocked by EX/MEM.
    drive(1'b1, 3'd2, 1'b0, 1'b0); to_sample(); check_outs("top_blk", 2'b01, 1'b0, 1'b0, 1'b1, 1'b0); next_cycle();
    drive(1'b0, 3'd0, 1'b1, 1'b0); to_sample();
    check("blk.stall_cycles", 32'(stall_cycles), 32'd1);
    next_cycle();

    // MULTI, nominal latency: start at T, stall T..T+3, load at T+4.
    do_reset();
    drive(1'b1, 3'd5, 1'b1, 1'b0);
    to_sample(); check_outs("mul.T0", 2'b11, 1'b0, 1'b1, 1'b1, 1'b0); next_cycle();
    to_sample(); check_outs("mul.T1", 2'b11, 1'b0, 1'b0, 1'b1, 1'b1); next_cycle();
    to_sample(); check_outs("mul.T2", 2'b11, 1'b0, 1'b0, 1'b1, 1'b1); next_cycle();
    to_sample(); check_outs("mul.T3", 2'b11, 1'b0, 1'b0, 1'b1, 1'b1); next_cycle();
    to_sample(); check_outs("mul.T4", 2'b11, 1'b1, 1'b0, 1'b0, 1'b1); next_cycle();
    // Back-to-back PASS right after the MULTI load.
    drive(1'b1, 3'd1, 1'b1, 1'b0);
    to_sample(); check_outs("mul.b2b", 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    check("mul.stall_cycles", 32'(stall_cycles), 32'd4);
    next_cycle();

    // MULTI with EX/MEM not ready for three cycles at cnt==0: load at T+7.
    do_reset();
    drive(1'b1, 3'd5, 1'b0, 1'b0);
    to_sample(); check_outs("mrdy.T0", 2'b11, 1'b0, 1'b1, 1'b1, 1'b0); next_cycle();
    for (int i = 1; i <= 6; i++) begin
      to_sample(); check_outs($sformatf("mrdy.T%0d", i), 2'b11, 1'b0, 1'b0, 1'b1, 1'b1); next_cycle();
    end
    ex_mem_ready = 1'b1;
    to_sample(); check_outs("mrdy.T7", 2'b11, 1'b1, 1'b0, 1'b0, 1'b1); next_cycle();
    drive(1'b0, 3'd0, 1'b1, 1'b0);
    to_sample(); check_outs("mrdy.T8", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mrdy.stall_cycles", 32'(stall_cycles), 32'd7);
    next_cycle();

    // Flush at T+2 of a MULTI: no load, back in IDLE at T+3.
    do_reset();
    drive(1'b1, 3'd5, 1'b1, 1'b0);
    next_cycle(); next_cycle();
    flush = 1'b1;
    to_sample(); check_outs("fl.T2", 2'b11, 1'b0, 1'b0, 1'b0, 1'b1); next_cycle();
    drive(1'b0, 3'd0, 1'b1, 1'b0);
    to_sample(); check_outs("fl.T3", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fl.stall_cycles", 32'(stall_cycles), 32'd2);
    next_cycle();

    // Flush coinciding with the load cycle wins.
    drive(1'b1, 3'd5, 1'b1, 1'b0);
    next_cycle(); next_cycle(); next_cycle(); next_cycle();
    flush = 1'b1;
    to_sample(); check_outs("fl0.T4", 2'b11, 1'b0, 1'b0, 1'b0, 1'b1); next_cycle();
    drive(1'b0, 3'd0, 1'b1, 1'b0);
    to_sample(); check_outs("fl0.T5", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fl0.stall_cycles", 32'(stall_cycles), 32'd6);
    next_cycle();

    // Flush of a single-cycle PASS: no load, no stall.
    drive(1'b1, 3'd1, 1'b1, 1'b1);
    to_sample(); check_outs("fl.pass", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); next_cycle();

    // Reset in the middle of a MULTI.
    do_reset();
    drive(1'b1, 3'd5, 1'b1, 1'b0);
    next_cycle();
    reset = 1'b1;
    to_sample(); check_outs("rstm.T1", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); next_cycle();
    reset = 1'b0;
    drive(1'b0, 3'd0, 1'b1, 1'b0);
    to_sample(); check_outs("rstm.T2", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rstm.stall_cycles", 32'(stall_cycles), 32'd0);
    next_cycle();

    // Saturation: PASS held against a blocked EX/MEM for 70000 cycles.
    do_reset();
    drive(1'b1, 3'd1, 1'b0, 1'b0);
    to_sample(); check_outs("sat.T0", 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    next_cycle();
    repeat (65533) @(posedge clock);
    #1;
    check("sat.fffe", 32'(stall_cycles), 32'h0000_FFFE);
    next_cycle();
    check("sat.ffff", 32'(stall_cycles), 32'h0000_FFFF);
    repeat (70000 - 65535) @(posedge clock);
    #1;
    check("sat.hold", 32'(stall_cycles), 32'h0000_FFFF);
    // Flush does not clear the counter.
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    id_ex_valid = 1'b0;
    check("sat.flush", 32'(stall_cycles), 32'h0000_FFFF);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
